// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI Master between NUM_REQ requesters.
// Latches the winner's slave/TX byte, pulses start, times the exchange and returns rx_data with done.
module spi_master_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int XFER_CYCLES = 21,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_slave,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 start,
    output logic [1:0]           slaveSelect,
    output logic [7:0]           masterDataToSend,
    input  logic [7:0]           masterDataReceived
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [NUM_REQ-1:0] grant_n, done_n;
    logic               err_n, busy_n, start_n;
    logic [7:0]         rx_data_n, tx_n;
    logic [1:0]         ss_n;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     cand;
    logic [1:0]         win_slave;
    logic [7:0]         win_data;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_slave = req_slave[{win, 1'b0} +: 2];
    assign win_data  = req_data[{win, 3'b000} +: 8];

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        owner_n   = owner;
        cnt_n     = cnt;
        grant_n   = grant;
        done_n    = done;
        err_n     = err;
        rx_data_n = rx_data;
        busy_n    = busy;
        start_n   = 1'b0;
        ss_n      = slaveSelect;
        tx_n      = masterDataToSend;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = win;
                    busy_n  = 1'b1;
                    if (win_slave == 2'd3) begin
                        // Slave 3 does not exist: answer at once without touching the Master.
                        done_n[win] = 1'b1;
                        err_n       = 1'b1;
                        state_n     = DONE;
                    end else begin
                        grant_n[win] = 1'b1;
                        ss_n         = win_slave;
                        tx_n         = win_data;
                        start_n      = 1'b1;
                        cnt_n        = CNT_W'(XFER_CYCLES - 1);
                        state_n      = XFER;
                    end
                end
            end
            XFER: begin
                if (cnt == '0) begin
                    rx_data_n     = masterDataReceived;
                    done_n[owner] = 1'b1;
                    err_n         = 1'b0;
                    grant_n       = '0;
                    state_n       = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                done_n   = '0;
                err_n    = 1'b0;
                busy_n   = 1'b0;
                state_n  = IDLE;
                rr_ptr_n = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            owner            <= '0;
            cnt              <= '0;
            grant            <= '0;
            done             <= '0;
            err              <= 1'b0;
            rx_data          <= '0;
            busy             <= 1'b0;
            start            <= 1'b0;
            slaveSelect      <= '0;
            masterDataToSend <= '0;
        end else begin
            state            <= state_n;
            rr_ptr           <= rr_ptr_n;
            owner            <= owner_n;
            cnt              <= cnt_n;
            grant            <= grant_n;
            done             <= done_n;
            err              <= err_n;
            rx_data          <= rx_data_n;
            busy             <= busy_n;
            start            <= start_n;
            slaveSelect      <= ss_n;
            masterDataToSend <= tx_n;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: SPI Master modelled as a loopback whose byte is valid only at the end
// of the exchange, with a round-robin reference model driven by randomized requests.
module tb_spi_master_arbiter;

    localparam int N  = 3;
    localparam int XC = 21;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [2*N-1:0] req_slave;
    logic [8*N-1:0] req_data;
    logic [N-1:0] grant, done;
    logic         err, busy, start;
    logic [7:0]   rx_data, masterDataToSend, masterDataReceived;
    logic [1:0]   slaveSelect;

    int checks = 0;
    int errors = 0;
    int inv_bad = 0;
    logic prev_busy = 1'b0;
    int age = 0;
    int rr_m = 0;
    logic [7:0] last_rx = 8'h00;

    spi_master_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XC), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .req_slave(req_slave), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .rx_data(rx_data), .busy(busy), .start(start),
        .slaveSelect(slaveSelect), .masterDataToSend(masterDataToSend),
        .masterDataReceived(masterDataReceived)
    );

    always #5 clk = ~clk;

    // Master model: the looped-back byte only becomes valid once the full exchange has elapsed.
    always @(posedge clk) begin
        if (reset) age <= 0;
        else if (start) age <= 1;
        else if (age != 0) age <= age + 1;
    end
    assign masterDataReceived = (age >= XC - 1) ? masterDataToSend : ~masterDataToSend;

    always @(negedge clk) begin
        if ($countones(grant) > 1 || $countones(done) > 1 || (start && prev_busy))
            inv_bad <= inv_bad + 1;
        prev_busy <= busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Waits for the next done pulse and reports what was observed along the way (no judging here).
    task automatic wait_done(input int budget, output int widx, output logic [7:0] wrx,
                             output logic werr, output int start_cnt, output int lat,
                             output int gidx, output bit ss_bad, output int dcyc, output bit timeout);
        int cyc;
        int start_at;
        logic [1:0] ss0;
        bit have_ss;
        cyc = 0; start_at = -1; have_ss = 0; ss0 = 2'd0;
        widx = -1; wrx = 8'h00; werr = 1'b0; start_cnt = 0; lat = -1; gidx = -1;
        ss_bad = 0; dcyc = -1; timeout = 1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (start) begin
                start_cnt++;
                if (start_at < 0) start_at = cyc;
            end
            if (grant != '0) begin
                if (gidx < 0) gidx = oh_idx(grant);
                if (!have_ss) begin ss0 = slaveSelect; have_ss = 1; end
                else if (slaveSelect !== ss0) ss_bad = 1;
            end
            if (done != '0) begin
                widx = oh_idx(done); wrx = rx_data; werr = err; dcyc = cyc;
                lat = (start_at < 0) ? -1 : cyc - start_at;
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0; rr_m = 0; last_rx = 8'h00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
        checks++; if (slaveSelect !== 2'd0) begin errors++; $display("FAIL reset_ss: got %0d expected 0", slaveSelect); end
        checks++; if (masterDataToSend !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h expected 00", masterDataToSend); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int w, sc, lat, g, dc; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave[1:0] = 2'd1; req_data[7:0] = 8'h53; req = 3'b001;
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = '0;
        checks++; if (to) begin errors++; $display("FAIL single_timeout: no done within budget"); end
        checks++; if (w != 0) begin errors++; $display("FAIL single_done_idx: got %0d expected 0", w); end
        checks++; if (rx !== 8'h53) begin errors++; $display("FAIL single_rx: got %h expected 53", rx); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", e); end
        checks++; if (sc != 1) begin errors++; $display("FAIL single_start_width: got %0d expected 1", sc); end
        checks++; if (lat != XC) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, XC); end
        checks++; if (g != 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", g); end
        checks++; if (ssb || slaveSelect !== 2'd1) begin errors++; $display("FAIL single_ss: got %0d stable=%0d expected 1 stable", slaveSelect, !ssb); end
        @(negedge clk);
        checks++; if (done !== 3'b000) begin errors++; $display("FAIL single_done_pulse: got %b expected 000", done); end
        checks++; if (rx_data !== 8'h53) begin errors++; $display("FAIL single_rx_hold: got %h expected 53", rx_data); end
    endtask

    task automatic test_all_three;
        int w, sc, lat, g, dc, exp; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave = {2'd2, 2'd1, 2'd0};
        req_data  = {8'h53, 8'hFF, 8'h3C};
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            exp = rr_pick(req, rr_m);
            wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
            if (t == 3) req = '0;
            checks++; if (w != exp) begin errors++; $display("FAIL all3_order[%0d]: got %0d expected %0d", t, w, exp); end
            checks++; if (rx !== req_data[8*exp +: 8]) begin errors++; $display("FAIL all3_rx[%0d]: got %h expected %h", t, rx, req_data[8*exp +: 8]); end
            rr_m = (exp + 1) % N;
        end
    endtask

    task automatic test_rr101;
        int w, sc, lat, g, dc, exp; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave = {2'd2, 2'd1, 2'd0};
        req_data  = {8'h7E, 8'h00, 8'hA1};
        req = 3'b001;
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        rr_m = 1;
        req = 3'b101;
        checks++; if (w != 0) begin errors++; $display("FAIL rr_first: got %0d expected 0", w); end
        exp = rr_pick(3'b101, rr_m);
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = 3'b001;
        checks++; if (w != exp) begin errors++; $display("FAIL rr_101_winner: got %0d expected %0d", w, exp); end
        checks++; if (rx !== 8'h7E) begin errors++; $display("FAIL rr_101_rx: got %h expected 7e", rx); end
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = '0;
        checks++; if (w != 0) begin errors++; $display("FAIL rr_101_second: got %0d expected 0", w); end
    endtask

    task automatic test_err;
        int w, sc, lat, g, dc; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave[3:2] = 2'd3; req_data[15:8] = 8'h99; req = 3'b010;
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = '0;
        checks++; if (w != 1) begin errors++; $display("FAIL err_done_idx: got %0d expected 1", w); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", e); end
        checks++; if (dc != 1) begin errors++; $display("FAIL err_delay: got %0d expected 1", dc); end
        checks++; if (sc != 0) begin errors++; $display("FAIL err_start: got %0d expected 0", sc); end
        checks++; if (g != -1) begin errors++; $display("FAIL err_grant: got %0d expected none", g); end
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL err_rx: got %h expected 00", rx); end
        @(negedge clk);
        checks++; if (done !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL err_pulse: got done=%b err=%b expected 000/0", done, err); end
    endtask

    task automatic test_reset_mid;
        int w, sc, lat, g, dc, n; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave = {2'd0, 2'd1, 2'd2};
        req_data  = {8'h00, 8'h2B, 8'h6D};
        req = 3'b001;
        n = 0;
        do begin @(negedge clk); n++; end while (!start && n < 5);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 3'b000 || busy !== 1'b0 || start !== 1'b0 || done !== 3'b000)
            begin errors++; $display("FAIL midreset_clear: got grant=%b busy=%b start=%b done=%b expected all 0", grant, busy, start, done); end
        reset = 1'b0; rr_m = 0;
        req = 3'b011;
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = 3'b010;
        checks++; if (w != 0 || rx !== 8'h6D) begin errors++; $display("FAIL midreset_first: got idx=%0d rx=%h expected 0/6d", w, rx); end
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        req = '0;
        checks++; if (w != 1 || rx !== 8'h2B) begin errors++; $display("FAIL midreset_second: got idx=%0d rx=%h expected 1/2b", w, rx); end
    endtask

    task automatic test_drop;
        int w, sc, lat, g, dc, n; logic [7:0] rx; logic e; bit ssb, to;
        apply_reset;
        req_slave[1:0] = 2'd2; req_data[7:0] = 8'hC5; req = 3'b001;
        n = 0;
        do begin @(negedge clk); n++; end while (!grant[0] && n < 10);
        checks++; if (!grant[0]) begin errors++; $display("FAIL drop_grant: got %b expected 001", grant); end
        repeat (5) @(negedge clk);
        req = '0; req_data[7:0] = 8'h11; req_slave[1:0] = 2'd0;
        wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
        checks++; if (w != 0) begin errors++; $display("FAIL drop_done: got %0d expected 0", w); end
        checks++; if (rx !== 8'hC5) begin errors++; $display("FAIL drop_rx: got %h expected c5", rx); end
        checks++; if (ssb || slaveSelect !== 2'd2) begin errors++; $display("FAIL drop_ss: got %0d expected 2", slaveSelect); end
    endtask

    task automatic test_random;
        int w, sc, lat, g, dc, exp, f; logic [7:0] rx; logic e; bit ssb, to;
        logic [N-1:0] pending;
        logic [1:0] slv [N];
        logic [7:0] dat [N];
        apply_reset;
        pending = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(1, 0) == 1) begin
                    slv[i] = ($urandom_range(5, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
                    dat[i] = 8'($urandom);
                    pending[i] = 1'b1;
                    req_slave[2*i +: 2] = slv[i];
                    req_data[8*i +: 8] = dat[i];
                end
            end
            if (pending == '0) begin
                f = it % N;
                slv[f] = 2'd0; dat[f] = 8'($urandom); pending[f] = 1'b1;
                req_slave[2*f +: 2] = slv[f]; req_data[8*f +: 8] = dat[f];
            end
            req = pending;
            exp = rr_pick(pending, rr_m);
            wait_done(200, w, rx, e, sc, lat, g, ssb, dc, to);
            checks++; if (w != exp) begin errors++; $display("FAIL rand_winner[%0d]: got %0d expected %0d", it, w, exp); end
            if (slv[exp] == 2'd3) begin
                checks++; if (e !== 1'b1 || rx !== last_rx || sc != 0)
                    begin errors++; $display("FAIL rand_reject[%0d]: got err=%b rx=%h starts=%0d expected 1/%h/0", it, e, rx, sc, last_rx); end
            end else begin
                checks++; if (e !== 1'b0 || rx !== dat[exp] || lat != XC)
                    begin errors++; $display("FAIL rand_xfer[%0d]: got err=%b rx=%h lat=%0d expected 0/%h/%0d", it, e, rx, lat, dat[exp], XC); end
                last_rx = dat[exp];
            end
            pending[exp] = 1'b0;
            rr_m = (exp + 1) % N;
            req = pending;
        end
        req = '0;
    endtask

    task automatic test_invariants;
        repeat (3) @(negedge clk);
        checks++; if (inv_bad != 0) begin errors++; $display("FAIL invariants: got %0d violations expected 0", inv_bad); end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_slave = '0; req_data = '0;
        test_reset;
        test_single;
        test_all_three;
        test_rr101;
        test_err;
        test_reset_mid;
        test_drop;
        test_random;
        test_invariants;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
